// File: rtl/pll_reset_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
package pll_reset_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        SDRAM_UP,
        RUN
    } state_e;

    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 1000000;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_CORE_DELAY_CYCLES   = 256;

    typedef struct packed {
        logic pll_rst;
        logic sdram_rst;
        logic core_rst;
        logic ready;
    } rst_outs_t;

    // Output levels are a pure function of the state being entered.
    function automatic rst_outs_t outs_for(state_e s);
        rst_outs_t o;
        o = '{pll_rst: 1'b0, sdram_rst: 1'b1, core_rst: 1'b1, ready: 1'b0};
        case (s)
            PLL_RST:  o.pll_rst   = 1'b1;
            SDRAM_UP: o.sdram_rst = 1'b0;
            RUN:      o = '{pll_rst: 1'b0, sdram_rst: 1'b0, core_rst: 1'b0, ready: 1'b1};
            default:  o.pll_rst   = 1'b0;
        endcase
        return o;
    endfunction

    function automatic int max_int(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// Sequences PLL reset, lock qualification and staged release of memory and core resets.
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int CORE_DELAY_CYCLES   = DEF_CORE_DELAY_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sdram_rst,
    output logic       core_rst,
    output logic       ready,
    output logic [7:0] relock_count
);

    // All cycle parameters are expected to be >= 1; the counter only ever reaches max-1.
    localparam int MAX_CYCLES = max_int(max_int(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                        max_int(LOCK_STABLE_CYCLES, CORE_DELAY_CYCLES));
    localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t PLL_RST_LAST = cnt_t'(PLL_RST_CYCLES - 1);
    localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
    localparam cnt_t STABLE_LAST  = cnt_t'(LOCK_STABLE_CYCLES - 1);
    localparam cnt_t CORE_LAST    = cnt_t'(CORE_DELAY_CYCLES - 1);

    state_e    state;
    cnt_t      cnt;
    rst_outs_t outs;
    logic      locked_s;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    // Outputs are loaded with the destination state's levels on the transition edge,
    // so they stay registered and change together with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= PLL_RST;
            cnt          <= '0;
            outs         <= outs_for(PLL_RST);
            relock_count <= '0;
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == PLL_RST_LAST) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                        outs  <= outs_for(WAIT_LOCK);
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                        outs  <= outs_for(STABLE);
                    end else if (cnt == TIMEOUT_LAST) begin
                        state <= PLL_RST;
                        cnt   <= '0;
                        outs  <= outs_for(PLL_RST);
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                        outs  <= outs_for(WAIT_LOCK);
                    end else if (cnt == STABLE_LAST) begin
                        state <= SDRAM_UP;
                        cnt   <= '0;
                        outs  <= outs_for(SDRAM_UP);
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                SDRAM_UP, RUN: begin
                    if (!locked_s) begin
                        state <= PLL_RST;
                        cnt   <= '0;
                        outs  <= outs_for(PLL_RST);
                        if (relock_count != 8'hFF) begin
                            relock_count <= relock_count + 8'd1;
                        end
                    end else if (state == SDRAM_UP) begin
                        if (cnt == CORE_LAST) begin
                            state <= RUN;
                            cnt   <= '0;
                            outs  <= outs_for(RUN);
                        end else begin
                            cnt <= cnt + cnt_t'(1);
                        end
                    end
                end
                default: begin
                    state <= PLL_RST;
                    cnt   <= '0;
                    outs  <= outs_for(PLL_RST);
                end
            endcase
        end
    end

    assign pll_rst   = outs.pll_rst;
    assign sdram_rst = outs.sdram_rst;
    assign core_rst  = outs.core_rst;
    assign ready     = outs.ready;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with small timing parameters (4/64/8/5).
module tb_pll_reset_seq;

    typedef struct packed {
        logic       pll_rst;
        logic       sdram_rst;
        logic       core_rst;
        logic       ready;
        logic [7:0] relock_count;
    } obs_t;

    typedef struct {
        logic  lk;
        int    cycles;
        obs_t  exp;
        string name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic       pll_rst;
    logic       sdram_rst;
    logic       core_rst;
    logic       ready;
    logic [7:0] relock_count;

    int checkCount = 0;
    int passCount  = 0;
    int violations = 0;

    vec_t vecs[20];

    always #5 clk = ~clk;

    pll_reset_seq #(
        .PLL_RST_CYCLES      (4),
        .LOCK_TIMEOUT_CYCLES (64),
        .LOCK_STABLE_CYCLES  (8),
        .CORE_DELAY_CYCLES   (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .locked       (locked),
        .pll_rst      (pll_rst),
        .sdram_rst    (sdram_rst),
        .core_rst     (core_rst),
        .ready        (ready),
        .relock_count (relock_count)
    );

    // Reset ordering must hold on every sampled cycle.
    always @(negedge clk) begin
        if (!rst && ((pll_rst && !sdram_rst) || (sdram_rst && !core_rst))) begin
            violations++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(logic lk, int n, logic p, logic s, logic c, logic r,
                                logic [7:0] rc, string name);
        vec_t v;
        v.lk     = lk;
        v.cycles = n;
        v.exp    = {p, s, c, r, rc};
        v.name   = name;
        return v;
    endfunction

    task automatic applyStimulus(input logic lk, input int n);
        locked = lk;
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input obs_t exp);
        obs_t act;
        act = {pll_rst, sdram_rst, core_rst, ready, relock_count};
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got pll=%0b sdram=%0b core=%0b ready=%0b relock=%0d, want pll=%0b sdram=%0b core=%0b ready=%0b relock=%0d",
                     name, act.pll_rst, act.sdram_rst, act.core_rst, act.ready, act.relock_count,
                     exp.pll_rst, exp.sdram_rst, exp.core_rst, exp.ready, exp.relock_count);
        end
    endtask

    task automatic timeoutFail(input string name);
        checkCount++;
        $display("[TB] FAIL %s: got no response within bound, want output change", name);
    endtask

    task automatic doReset();
        rst    = 1'b1;
        locked = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_hold", {1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
        rst = 1'b0;
    endtask

    initial begin
        int   waited;
        logic [7:0] expRc;
        logic expPll;
        logic aborted;

        // Continuous sequence: lock, run, loss, glitchy relock, loss from RUN.
        vecs[0]  = mk(1'b0,  0, 1, 1, 1, 0, 8'd0, "post_reset");
        vecs[1]  = mk(1'b0,  3, 1, 1, 1, 0, 8'd0, "pll_rst_hold");
        vecs[2]  = mk(1'b0,  1, 0, 1, 1, 0, 8'd0, "pll_rst_end");
        vecs[3]  = mk(1'b0,  2, 0, 1, 1, 0, 8'd0, "wait_lock");
        vecs[4]  = mk(1'b1, 10, 0, 1, 1, 0, 8'd0, "stable_hold");
        vecs[5]  = mk(1'b1,  1, 0, 0, 1, 0, 8'd0, "sdram_release");
        vecs[6]  = mk(1'b1,  4, 0, 0, 1, 0, 8'd0, "core_delay");
        vecs[7]  = mk(1'b1,  1, 0, 0, 0, 1, 8'd0, "core_release");
        vecs[8]  = mk(1'b1, 20, 0, 0, 0, 1, 8'd0, "run_hold");
        vecs[9]  = mk(1'b0,  2, 0, 0, 0, 1, 8'd0, "loss_sync");
        vecs[10] = mk(1'b0,  1, 1, 1, 1, 0, 8'd1, "loss_reset");
        vecs[11] = mk(1'b0,  3, 1, 1, 1, 0, 8'd1, "relock_pll_hold");
        vecs[12] = mk(1'b0,  1, 0, 1, 1, 0, 8'd1, "relock_wait");
        vecs[13] = mk(1'b1,  5, 0, 1, 1, 0, 8'd1, "glitch_high");
        vecs[14] = mk(1'b0,  1, 0, 1, 1, 0, 8'd1, "glitch_low");
        vecs[15] = mk(1'b1, 10, 0, 1, 1, 0, 8'd1, "glitch_restable");
        vecs[16] = mk(1'b1,  1, 0, 0, 1, 0, 8'd1, "glitch_sdram_up");
        vecs[17] = mk(1'b1,  5, 0, 0, 0, 1, 8'd1, "glitch_run");
        vecs[18] = mk(1'b0,  2, 0, 0, 0, 1, 8'd1, "loss2_sync");
        vecs[19] = mk(1'b0,  1, 1, 1, 1, 0, 8'd2, "loss2_reset");

        rst    = 1'b1;
        locked = 1'b0;

        // Power-up with no lock: 4 cycles of pll_rst in every 68.
        doReset();
        for (int k = 0; k < 140; k++) begin
            expPll = ((k % 68) < 4);
            checkOutput($sformatf("powerup_k%0d", k), {expPll, 1'b1, 1'b1, 1'b0, 8'd0});
            applyStimulus(1'b0, 1);
        end

        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].lk, vecs[i].cycles);
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        // Repeated lock losses from SDRAM_UP until the counter saturates.
        aborted = 1'b0;
        for (int ev = 3; ev <= 300 && !aborted; ev++) begin
            locked = 1'b1;
            waited = 0;
            while (sdram_rst && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            if (sdram_rst) begin
                timeoutFail($sformatf("sat_lock_ev%0d", ev));
                aborted = 1'b1;
            end else begin
                locked = 1'b0;
                waited = 0;
                while (!pll_rst && waited < 10) begin
                    @(negedge clk);
                    waited++;
                end
                if (!pll_rst) begin
                    timeoutFail($sformatf("sat_loss_ev%0d", ev));
                    aborted = 1'b1;
                end else begin
                    expRc = (ev > 255) ? 8'd255 : 8'(ev);
                    checkOutput($sformatf("sat_ev%0d", ev), {1'b1, 1'b1, 1'b1, 1'b0, expRc});
                end
            end
        end

        // Asynchronous reset in SDRAM_UP, then full restart with lock already present.
        locked = 1'b1;
        waited = 0;
        while (sdram_rst && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (sdram_rst) begin
            timeoutFail("midup_reach");
        end else begin
            checkOutput("midup_state", {1'b0, 1'b0, 1'b1, 1'b0, 8'd255});
            #2 rst = 1'b1;
            #1 checkOutput("async_reset", {1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
            @(negedge clk);
            rst = 1'b0;
            applyStimulus(1'b1, 3);
            checkOutput("restart_pll_hold", {1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
            applyStimulus(1'b1, 1);
            checkOutput("restart_pll_end", {1'b0, 1'b1, 1'b1, 1'b0, 8'd0});
            applyStimulus(1'b1, 8);
            checkOutput("restart_stable", {1'b0, 1'b1, 1'b1, 1'b0, 8'd0});
            applyStimulus(1'b1, 1);
            checkOutput("restart_sdram_up", {1'b0, 1'b0, 1'b1, 1'b0, 8'd0});
        end

        checkCount++;
        if (violations == 0) begin
            passCount++;
        end else begin
            $display("[TB] FAIL ordering: got %0d violating cycles, want 0", violations);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16, number of cycles pll_rst is held high per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 1000000, number of cycles in WAIT_LOCK without lock before the PLL is reset again.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, number of consecutive synchronized-lock cycles required before releasing sdram_rst.
REQ-004 SHALL have parameter CORE_DELAY_CYCLES, default 256, number of cycles between sdram_rst release and core_rst release.
REQ-005 SHALL have port clk, input, 1, free-running reference clock (same source as the PLL refclk, not a PLL output).
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port locked, input, 1, PLL lock indication, asynchronous to clk.
REQ-008 SHALL have port pll_rst, output, 1, reset to the PLL, active-high.
REQ-009 SHALL have port sdram_rst, output, 1, active-high reset for the memory-side clock domains.
REQ-010 SHALL have port core_rst, output, 1, active-high reset for the core clock domains.
REQ-011 SHALL have port ready, output, 1, high only in RUN.
REQ-012 SHALL have port relock_count, output, 8, count of lock losses after reaching SDRAM_UP or RUN.

Function
REQ-013 SHALL synchronize locked through two clk flops; locked_s (second flop) is the only lock signal used by the FSM.
REQ-014 SHALL implement FSM states PLL_RST, WAIT_LOCK, STABLE, SDRAM_UP, RUN, sharing one cycle counter cnt that clears on every state change.
REQ-015 PLL_RST: pll_rst=1; transition to WAIT_LOCK at the edge where cnt==PLL_RST_CYCLES-1, so pll_rst is high exactly PLL_RST_CYCLES cycles.
REQ-016 WAIT_LOCK: locked_s=1 -> STABLE; otherwise at cnt==LOCK_TIMEOUT_CYCLES-1 -> PLL_RST; otherwise cnt++.
REQ-017 STABLE: locked_s=0 -> WAIT_LOCK with timeout restarted; at cnt==LOCK_STABLE_CYCLES-1 -> SDRAM_UP; otherwise cnt++.
REQ-018 SDRAM_UP: sdram_rst=0; at cnt==CORE_DELAY_CYCLES-1 -> RUN; otherwise cnt++.
REQ-019 RUN: sdram_rst=0, core_rst=0, ready=1.
REQ-020 locked_s=0 in SDRAM_UP or RUN SHALL go to PLL_RST next edge, reasserting sdram_rst and core_rst and clearing ready on that edge; relock_count increments by 1, saturating at 255.
REQ-021 All outputs SHALL be registered, with no combinational path from locked to any output.
REQ-022 Latency: with locked stable high from sampling edge 0 while in WAIT_LOCK, sdram_rst SHALL fall after edge LOCK_STABLE_CYCLES+2 and core_rst after edge LOCK_STABLE_CYCLES+2+CORE_DELAY_CYCLES.
REQ-023 sdram_rst SHALL never be low while pll_rst is high; core_rst SHALL never be low while sdram_rst is high.
REQ-024 cnt width SHALL be clog2 of the largest parameter; all parameters SHALL be >=1.

Reset
REQ-025 On rst assertion, asynchronously: state=PLL_RST, cnt=0, sync flops=0, pll_rst=1, sdram_rst=1, core_rst=1, ready=0, relock_count=0.
REQ-026 After rst deassertion mid-operation, the full sequence SHALL restart from PLL_RST regardless of locked.

Structure
REQ-027 Package pll_reset_pkg SHALL hold the state enum and default parameter constants.
REQ-028 The two-flop synchronizer SHALL be sub-module sync_2ff; all other logic stays in pll_reset_seq.
REQ-029 Consumers SHALL re-synchronize sdram_rst/core_rst into their own PLL clock domains; that logic is outside this block.

Verification
Use PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=64, LOCK_STABLE_CYCLES=8, CORE_DELAY_CYCLES=5.
REQ-030 Power-up: rst pulse, locked=0 throughout -> pll_rst high 4 cycles, low 64 cycles, repeating; sdram_rst/core_rst stay 1, ready stays 0.
REQ-031 Normal lock: locked rises in WAIT_LOCK -> sdram_rst falls after edge 10, core_rst and ready change after edge 15; relock_count=0.
REQ-032 Glitchy lock: locked high 5 cycles, low 1, then high -> STABLE aborts to WAIT_LOCK; sdram_rst releases 10 edges after the final rise.
REQ-033 Lock loss in RUN: locked drops -> next edge after locked_s falls, all resets asserted, ready=0, relock_count=1, pll_rst pulse of 4 cycles follows.
REQ-034 Saturation and reset: 300 lock-loss events -> relock_count=255; rst asserted mid-SDRAM_UP -> all outputs return to reset values immediately.
